vape_output_protection_mdma: RTL and testbench

Parametrised successor to the single-DMA VAPE output-region monitor. Watches PC and NUM_CH independent DMA write channels. Drops `exec` when any channel writes the output region (OR) while the CPU is outside the executable region (ER). Adds violation reporting: a one-cycle pulse, the first offending channel and a saturating violation counter. Sits beside the other VRASED hw-mod monitors; `exec` feeds the attestation/proof logic.

---
 rtl/vape_output_protection_mdma_if.sv | 11 +
 rtl/vape_output_protection_mdma.sv | 71 +++++++
 tb/tb_vape_output_protection_mdma.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vape_output_protection_mdma_if.sv
// vape_output_protection_mdma_if: CPU program counter and packed DMA write channels observed by the monitor
interface vape_output_protection_mdma_if #(
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2
);
  logic [ADDR_W-1:0]        pc;
  logic [NUM_CH*ADDR_W-1:0] dma_addr;
  logic [NUM_CH-1:0]        dma_en;
  modport master (output pc, dma_addr, dma_en);
  modport slave  (input  pc, dma_addr, dma_en);
endinterface

// File: rtl/vape_output_protection_mdma.sv
// vape_output_protection_mdma: multi-channel DMA output-region monitor with violation reporting
// Optional VAPE_ER_EXIT_CHECK_EN adds ER exit/entry checks via a registered prev_pc.
module vape_output_protection_mdma #(
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2,
  parameter int CNT_W = 8,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = '0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vape_output_protection_mdma_if.slave bus,
  input  logic [ADDR_W-1:0]    ER_min,
  input  logic [ADDR_W-1:0]    ER_max,
  input  logic [ADDR_W-1:0]    OR_min,
  input  logic [ADDR_W-1:0]    OR_max,
  input  logic                 viol_cnt_clr,
  output logic                 exec,
  output logic                 viol_pulse,
  output logic [CH_W-1:0]      viol_ch,
  output logic [CNT_W-1:0]     viol_cnt
);
  typedef enum logic {ABORT = 1'b0, EXEC = 1'b1} state_t;
  state_t state;
  logic [NUM_CH-1:0] or_hit;
  logic [CH_W-1:0] first_ch;
  logic pc_in_er, is_fst_er, is_reset, dma_viol, er_viol, viol;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
    assign or_hit[g] = bus.dma_en[g] && OR_min <= bus.dma_addr[g*ADDR_W +: ADDR_W]
                       && bus.dma_addr[g*ADDR_W +: ADDR_W] <= OR_max;
  end
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) first_ch = or_hit[i] ? CH_W'(i) : first_ch;
  end
  assign pc_in_er  = ER_min <= bus.pc && bus.pc <= ER_max;
  assign is_fst_er = bus.pc == ER_min;
  assign is_reset  = bus.pc == RESET_HANDLER;
  assign dma_viol  = !is_reset && state == EXEC && |or_hit && !pc_in_er;
`ifdef VAPE_ER_EXIT_CHECK_EN
  logic [ADDR_W-1:0] prev_pc;
  logic prev_in_er;
  assign prev_in_er = ER_min <= prev_pc && prev_pc <= ER_max;
  assign er_viol = !is_reset && state == EXEC &&
                   ((prev_in_er && !pc_in_er && prev_pc != ER_max) ||
                    (!prev_in_er && pc_in_er && bus.pc != ER_min));
`else
  assign er_viol = 1'b0;
`endif
  assign viol = dma_viol || er_viol;
  assign exec = state == EXEC;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= ABORT;
      viol_pulse <= 1'b0;
      viol_ch    <= '0;
      viol_cnt   <= '0;
`ifdef VAPE_ER_EXIT_CHECK_EN
      prev_pc    <= RESET_HANDLER;
`endif
    end else begin
      state      <= (is_reset || viol) ? ABORT : (state == ABORT && is_fst_er) ? EXEC : state;
      viol_pulse <= viol;
      viol_ch    <= dma_viol ? first_ch : viol_ch;
      // a clear coinciding with a violation still records that violation
      viol_cnt   <= viol_cnt_clr ? CNT_W'(viol) : (viol && !(&viol_cnt)) ? viol_cnt + CNT_W'(1) : viol_cnt;
`ifdef VAPE_ER_EXIT_CHECK_EN
      prev_pc    <= bus.pc;
`endif
    end
endmodule

// File: tb/tb_vape_output_protection_mdma.sv
// tb_vape_output_protection_mdma: directed self-checking bench for vape_output_protection_mdma
module tb_vape_output_protection_mdma;
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] er_min, er_max, or_min, or_max;
  logic viol_cnt_clr;
  logic exec, viol_pulse;
  logic [0:0] viol_ch;
  logic [7:0] viol_cnt;
  int errors = 0;
  int checks = 0;
  vape_output_protection_mdma_if #(.ADDR_W(16), .NUM_CH(2)) bus ();
  vape_output_protection_mdma #(.ADDR_W(16), .NUM_CH(2), .CNT_W(8), .RESET_HANDLER(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .ER_min(er_min), .ER_max(er_max), .OR_min(or_min), .OR_max(or_max),
    .viol_cnt_clr(viol_cnt_clr), .exec(exec), .viol_pulse(viol_pulse),
    .viol_ch(viol_ch), .viol_cnt(viol_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] pc, input logic [1:0] en, input logic [15:0] a0, input logic [15:0] a1);
    bus.pc = pc;
    bus.dma_en = en;
    bus.dma_addr = {a1, a0};
  endtask
  initial begin
    reset_n = 1'b0;
    viol_cnt_clr = 1'b0;
    er_min = 16'hE000; er_max = 16'hE0FF;
    or_min = 16'h0200; or_max = 16'h021F;
    drive(16'h0100, 2'b00, 16'h0000, 16'h0000);
    #12;
    check("rst_exec", exec, 0);
    check("rst_cnt", viol_cnt, 0);
    check("rst_pulse", viol_pulse, 0);
    check("rst_ch", viol_ch, 0);
    reset_n = 1'b1;
    step();
    check("idle_exec", exec, 0);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    check("enter_exec", exec, 1);
    drive(16'h0100, 2'b10, 16'h0000, 16'h0210);
    step();
    check("v1_exec", exec, 0);
    check("v1_pulse", viol_pulse, 1);
    check("v1_ch", viol_ch, 1);
    check("v1_cnt", viol_cnt, 1);
    step();
    check("v1_pulse_off", viol_pulse, 0);
    check("v1_cnt_hold", viol_cnt, 1);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'hE010, 2'b11, 16'h0200, 16'h0200);
    step();
    check("in_er_exec", exec, 1);
    check("in_er_pulse", viol_pulse, 0);
    or_min = 16'h0300;
    drive(16'hE0FF, 2'b11, 16'h0200, 16'h0200);
    step();
    drive(16'h0100, 2'b11, 16'h0200, 16'h0200);
    step();
    check("empty_or_exec", exec, 1);
    check("empty_or_cnt", viol_cnt, 1);
    or_min = 16'h0200;
    step();
    check("both_exec", exec, 0);
    check("both_ch", viol_ch, 0);
    check("both_cnt", viol_cnt, 2);
    for (int i = 0; i < 260; i++) begin
      drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
      step();
      drive(16'h0100, 2'b11, 16'h0200, 16'h021F);
      step();
    end
    check("sat_cnt", viol_cnt, 8'hFF);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'h0100, 2'b01, 16'h021F, 16'h0000);
    viol_cnt_clr = 1'b1;
    step();
    check("clr_viol_cnt", viol_cnt, 1);
    check("clr_viol_pulse", viol_pulse, 1);
    step();
    viol_cnt_clr = 1'b0;
    check("clr_cnt", viol_cnt, 0);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'h0100, 2'b10, 16'h0000, 16'h0201);
    step();
    check("pre_reset_ch", viol_ch, 1);
    check("pre_reset_cnt", viol_cnt, 1);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    check("pre_reset_exec", exec, 1);
    drive(16'h0000, 2'b01, 16'h0205, 16'h0000);
    step();
    check("pcreset_exec", exec, 0);
    check("pcreset_pulse", viol_pulse, 0);
    check("pcreset_cnt", viol_cnt, 1);
    check("pcreset_ch", viol_ch, 1);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    check("async_pre_exec", exec, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_exec", exec, 0);
    check("async_cnt", viol_cnt, 0);
    check("async_ch", viol_ch, 0);
    #2 reset_n = 1'b1;
    step();
    step();
    check("post_rst_exec", exec, 1);
    drive(16'hE010, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'h4000, 2'b00, 16'h0000, 16'h0000);
    step();
`ifdef VAPE_ER_EXIT_CHECK_EN
    check("exit_mid_exec", exec, 0);
    check("exit_mid_pulse", viol_pulse, 1);
    check("exit_mid_cnt", viol_cnt, 1);
    drive(16'hE000, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'hE0FF, 2'b00, 16'h0000, 16'h0000);
    step();
    drive(16'h4000, 2'b00, 16'h0000, 16'h0000);
    step();
    check("exit_max_exec", exec, 1);
    check("exit_max_pulse", viol_pulse, 0);
    drive(16'hE010, 2'b00, 16'h0000, 16'h0000);
    step();
    check("entry_mid_exec", exec, 0);
    check("entry_mid_cnt", viol_cnt, 2);
`else
    check("exit_nocheck_exec", exec, 1);
    check("exit_nocheck_pulse", viol_pulse, 0);
    check("exit_nocheck_cnt", viol_cnt, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
